// File: rtl/dmem_store_buffer_if.sv
// Store-buffer port bundle: MEM-stage request/lookup signals and the data-memory write channel.
// No storage; carries signals only.
// Backpressure flows through stall (toward MEM) and mem_ready (from memory).
interface dmem_store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 3
);
    logic          memwrite;
    logic          memread;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          stall;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [CW-1:0] count;

    // Store buffer side
    modport slave (
        input  memwrite, memread, dataadr, writedata, mem_ready,
        output stall, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata, count
    );

    // Pipeline / memory environment side
    modport master (
        output memwrite, memread, dataadr, writedata, mem_ready,
        input  stall, fwd_hit, fwd_data, mem_we, mem_addr, mem_wdata, count
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer: in-order FIFO of word stores retired to data memory, with load forwarding.
// Latency: a store accepted at edge T is presented to memory right after T when the buffer was empty.
// Backpressure: stall only when full (no same-cycle drain bypass); head retires on mem_we & mem_ready.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_store_buffer_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];

    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;
    logic             fwd_hit_c;
    logic [DW-1:0]    fwd_data_c;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // A full buffer refuses stores even if the head drains this cycle; keeps stall off the mem_ready path.
    assign enq   = bus.memwrite & ~full;
    assign deq   = ~empty & bus.mem_ready;

    assign bus.stall     = bus.memwrite & full;
    assign bus.mem_we    = ~empty;
    assign bus.mem_addr  = addr_q[head_q];
    assign bus.mem_wdata = data_q[head_q];
    assign bus.count     = count_q;
    assign bus.fwd_hit   = fwd_hit_c;
    assign bus.fwd_data  = fwd_data_c;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + 1'b1;
            if (deq) head_q <= head_q + 1'b1;
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Per-entry valid bits; enqueue and drain never target the same slot in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            if (deq) valid_q[head_q] <= 1'b0;
            if (enq) valid_q[tail_q] <= 1'b1;
        end
    end

    // Entry payload capture at the tail; contents are meaningless until marked valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= bus.dataadr;
            data_q[tail_q] <= bus.writedata;
        end
    end

    // Forwarding: scan oldest to youngest so the youngest word-address match wins.
    always_comb begin
        logic          lookup;
        logic [PW-1:0] idx;
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        idx        = head_q;
        lookup     = bus.memread & ~bus.memwrite;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (lookup && (CW'(i) < count_q) && valid_q[idx] &&
                (addr_q[idx][AW-1:2] == bus.dataadr[AW-1:2])) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer (DEPTH=4, 32-bit address/data).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Memory writes are logged at the falling edge when mem_we & mem_ready will fire.
module tb_dmem_store_buffer;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [63:0] wr_log [$];
    logic [63:0] exp_q  [$];

    dmem_store_buffer_if #(.AW(32), .DW(32), .CW(3)) bus ();

    dmem_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && bus.mem_we && bus.mem_ready)
            wr_log.push_back({bus.mem_addr, bus.mem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic we, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
        bus.memwrite  = we;
        bus.memread   = rd;
        bus.dataadr   = a;
        bus.writedata = d;
        bus.mem_ready = rdy;
        #1;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, 64'(wr_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < wr_log.size())
                chk($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_q[i]);
        end
        wr_log.delete();
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int c = 0; c < 20 && bus.count != 3'd0; c++) cyc();
        chk({tag, "_drained"}, 64'(bus.count), 64'd0);
    endtask

    initial begin
        int          i;
        logic        r;
        logic        stalled;

        // ---------------- reset state ----------------
        reset = 1'b0;
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc();
        cyc();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
        reset = 1'b1;

        // ---------------- basic retire ----------------
        drv(1'b1, 1'b0, 32'h50, 32'h7, 1'b1);
        chk("br_empty_we", 64'(bus.mem_we), 64'd0);
        expect_wr(32'h50, 32'h7);
        cyc();
        drv(1'b1, 1'b0, 32'h54, 32'h7, 1'b1);
        chk("br_w0_we", 64'(bus.mem_we), 64'd1);
        chk("br_w0_addr", 64'(bus.mem_addr), 64'h50);
        chk("br_w0_data", 64'(bus.mem_wdata), 64'h7);
        chk("br_w0_count", 64'(bus.count), 64'd1);
        expect_wr(32'h54, 32'h7);
        cyc();
        drv(1'b1, 1'b0, 32'h58, 32'h4e, 1'b1);
        chk("br_w1_addr", 64'(bus.mem_addr), 64'h54);
        chk("br_w1_count", 64'(bus.count), 64'd1);
        expect_wr(32'h58, 32'h4e);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("br_w2_addr", 64'(bus.mem_addr), 64'h58);
        chk("br_w2_data", 64'(bus.mem_wdata), 64'h4e);
        cyc();
        chk("br_end_count", 64'(bus.count), 64'd0);
        chk("br_end_we", 64'(bus.mem_we), 64'd0);
        check_writes("br");

        // ---------------- fill and stall ----------------
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 1'b0, 32'h70 + 32'(4 * k), 32'hA0 + 32'(k), 1'b0);
            chk($sformatf("fs_nostall%0d", k), 64'(bus.stall), 64'd0);
            expect_wr(32'h70 + 32'(4 * k), 32'hA0 + 32'(k));
            cyc();
        end
        drv(1'b1, 1'b0, 32'h80, 32'hA4, 1'b0);
        chk("fs_full_count", 64'(bus.count), 64'd4);
        chk("fs_full_stall", 64'(bus.stall), 64'd1);
        cyc();
        chk("fs_held_count", 64'(bus.count), 64'd4);
        drv(1'b1, 1'b0, 32'h80, 32'hA4, 1'b1);
        chk("fs_drain_still_stall", 64'(bus.stall), 64'd1);
        chk("fs_head_addr", 64'(bus.mem_addr), 64'h70);
        cyc();
        chk("fs_after_retire_count", 64'(bus.count), 64'd3);
        chk("fs_after_retire_stall", 64'(bus.stall), 64'd0);
        chk("fs_after_retire_head", 64'(bus.mem_addr), 64'h74);
        expect_wr(32'h80, 32'hA4);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("fs_accept_count", 64'(bus.count), 64'd3);
        chk("fs_accept_head", 64'(bus.mem_addr), 64'h78);
        drain("fs");
        check_writes("fs");

        // ---------------- simultaneous enqueue and drain ----------------
        drv(1'b1, 1'b0, 32'h90, 32'h1, 1'b0);
        expect_wr(32'h90, 32'h1);
        cyc();
        drv(1'b1, 1'b0, 32'h94, 32'h2, 1'b0);
        expect_wr(32'h94, 32'h2);
        cyc();
        drv(1'b1, 1'b0, 32'h98, 32'h3, 1'b1);
        chk("sd_pre_count", 64'(bus.count), 64'd2);
        chk("sd_pre_head", 64'(bus.mem_addr), 64'h90);
        expect_wr(32'h98, 32'h3);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("sd_post_count", 64'(bus.count), 64'd2);
        chk("sd_post_head", 64'(bus.mem_addr), 64'h94);
        drain("sd");
        check_writes("sd");

        // ---------------- forwarding ----------------
        drv(1'b1, 1'b0, 32'h5C, 32'h11, 1'b0);
        expect_wr(32'h5C, 32'h11);
        cyc();
        drv(1'b1, 1'b0, 32'h5C, 32'h28, 1'b0);
        expect_wr(32'h5C, 32'h28);
        cyc();
        drv(1'b0, 1'b1, 32'h5C, 32'h0, 1'b0);
        chk("fw_hit_5c", 64'(bus.fwd_hit), 64'd1);
        chk("fw_data_5c", 64'(bus.fwd_data), 64'h28);
        drv(1'b0, 1'b1, 32'h5E, 32'h0, 1'b0);
        chk("fw_hit_5e", 64'(bus.fwd_hit), 64'd1);
        chk("fw_data_5e", 64'(bus.fwd_data), 64'h28);
        drv(1'b0, 1'b1, 32'h60, 32'h0, 1'b0);
        chk("fw_miss_hit", 64'(bus.fwd_hit), 64'd0);
        chk("fw_miss_data", 64'(bus.fwd_data), 64'h0);
        drv(1'b1, 1'b1, 32'h5C, 32'h33, 1'b0);
        chk("fw_rdwr_hit", 64'(bus.fwd_hit), 64'd0);
        expect_wr(32'h5C, 32'h33);
        cyc();
        drv(1'b0, 1'b1, 32'h5C, 32'h0, 1'b0);
        chk("fw_new_visible", 64'(bus.fwd_data), 64'h33);
        chk("fw_new_count", 64'(bus.count), 64'd3);
        drv(1'b0, 1'b1, 32'h5C, 32'h0, 1'b1);
        cyc();
        cyc();
        chk("fw_one_left", 64'(bus.count), 64'd1);
        chk("fw_head_drain_hit", 64'(bus.fwd_hit), 64'd1);
        chk("fw_head_drain_data", 64'(bus.fwd_data), 64'h33);
        cyc();
        chk("fw_stale_hit", 64'(bus.fwd_hit), 64'd0);
        check_writes("fw");

        // ---------------- wrap-around ----------------
        i = 0;
        r = 1'b1;
        for (int c = 0; c < 40 && i < 10; c++) begin
            drv(1'b1, 1'b0, 32'h50 + 32'(4 * i), 32'(i), r);
            stalled = bus.stall;
            if (!stalled) expect_wr(32'h50 + 32'(4 * i), 32'(i));
            cyc();
            if (!stalled) i++;
            r = ~r;
        end
        chk("wr_all_accepted", 64'(i), 64'd10);
        drain("wr");
        check_writes("wr");

        // ---------------- reset mid-operation ----------------
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 1'b0, 32'hA0 + 32'(4 * k), 32'hB0 + 32'(k), 1'b0);
            cyc();
        end
        drv(1'b0, 1'b1, 32'hA0, 32'h0, 1'b0);
        chk("rm_pre_count", 64'(bus.count), 64'd3);
        reset = 1'b0;
        #1;
        chk("rm_we", 64'(bus.mem_we), 64'd0);
        chk("rm_count", 64'(bus.count), 64'd0);
        chk("rm_stall", 64'(bus.stall), 64'd0);
        chk("rm_fwd_hit", 64'(bus.fwd_hit), 64'd0);
        cyc();
        reset = 1'b1;
        drv(1'b1, 1'b0, 32'h64, 32'h0, 1'b1);
        chk("rm_post_empty", 64'(bus.mem_we), 64'd0);
        expect_wr(32'h64, 32'h0);
        cyc();
        drv(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("rm_new_addr", 64'(bus.mem_addr), 64'h64);
        chk("rm_new_count", 64'(bus.count), 64'd1);
        cyc();
        cyc();
        cyc();
        chk("rm_end_count", 64'(bus.count), 64'd0);
        check_writes("rm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write store buffer between the pipeline's MEM stage and data memory. It accepts word stores (`memwrite`/`dataadr`/`writedata`) from MEM in one cycle and retires them in order to data memory under a ready handshake. It forwards buffered store data to loads that hit a pending entry, and it stalls the pipeline only when the buffer is full. Memory writes seen at `top`'s `memwrite`/`dataadr`/`writedata` ports are this block's downstream writes.

## Interface
- `DEPTH`, 4: number of entries; must be a power of 2, minimum 2.
- `AW`, 32: address width.
- `DW`, 32: data width.

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `memwrite`  in  1: store request from MEM stage.
- `memread`  in  1: load request from MEM stage.
- `dataadr`  in  AW: store/load byte address from MEM stage.
- `writedata`  in  DW: store data.
- `stall`  out  1: asserted when the pipeline must hold MEM.
- `fwd_hit`  out  1: load address matches a pending entry.
- `fwd_data`  out  DW: data of the youngest matching entry.
- `mem_we`  out  1: write request to data memory.
- `mem_addr`  out  AW: head entry address.
- `mem_wdata`  out  DW: head entry data.
- `mem_ready`  in  1: data memory accepts the head write this cycle.
- `count`  out  $clog2(DEPTH)+1: number of valid entries.

## Operation
- Storage is a circular FIFO with a head pointer, a tail pointer and `count`. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- **Enqueue:** when `memwrite` is high and `count < DEPTH`, {`dataadr`, `writedata`} is written at tail on the rising edge and tail increments.
- **Stall:** `stall` = `memwrite & (count == DEPTH)`, purely combinational. A full buffer never accepts a store, even when a drain occurs in the same cycle. The stalled store is re-presented by the held pipeline.
- **Drain:** `mem_we` = `(count != 0)`. `mem_addr` and `mem_wdata` show the head entry. When `mem_we & mem_ready` at a rising edge, head increments.
- **Simultaneous enqueue and drain:** `count` is unchanged and both pointers advance.
- **Count:**
  - enqueue only: `count` +1.
  - drain only: `count` -1.
  - neither: `count` unchanged.
- **Forwarding:** when `memread` is high and `memwrite` is low, compare `dataadr[AW-1:2]` against every valid entry's address bits [AW-1:2].
  - Bits [1:0] are ignored for the compare; stores are word-sized.
  - On a match, `fwd_hit` = 1 and `fwd_data` = the youngest matching entry (nearest tail).
  - Forwarding includes the head entry, even while it is being drained that cycle.
  - With no match, `fwd_hit` = 0 and `fwd_data` = 0.
- A store enqueueing in the same cycle is not visible to forwarding until the next cycle. `memread` and `memwrite` both high gives `fwd_hit` = 0.
- Entries beyond `count` are don't-care and never drive forwarding.
- **Reset (asserted low, asynchronous):**
  - head, tail and `count` are cleared to 0.
  - all entry valid state is cleared.
  - outputs go to `mem_we` = 0, `stall` = 0 (when `memwrite` is low), `fwd_hit` = 0, `count` = 0.
  - any stores still in the buffer are discarded.
  - entry data registers need no reset.

## Timing
- A store accepted at edge T appears on `mem_we`/`mem_addr`/`mem_wdata` right after edge T when the buffer was empty. The minimum enqueue-to-memory latency is one cycle.
- Throughput is one enqueue and one retire per cycle.
- `stall`, `fwd_hit`, `fwd_data` and `mem_we` are combinational from registered state and current inputs; there are no internal combinational loops. `mem_ready` affects only the next state.
- Reset deassertion is synchronized externally. The first enqueue is permitted on the first rising edge with `reset` high.
- Stores retire in strict program order. No merging, no reordering, no dropping except on reset.

## Test plan
- **Basic retire:** reset, then store 0x7→0x50, 0x7→0x54, 0x4e→0x58 on consecutive cycles with `mem_ready` = 1 → memory sees exactly those three writes in order, each one cycle after acceptance, and `count` returns to 0.
- **Fill and stall:** `mem_ready` = 0, five consecutive stores → `count` reaches 4 and `stall` = 1 on the fifth. Raise `mem_ready` → the fifth store is accepted the cycle after the first retire, and all five retire in order.
- **Forward youngest:** with `mem_ready` = 0, store 0x11→0x5C then 0x28→0x5C, then load 0x5C → `fwd_hit` = 1, `fwd_data` = 0x28. Load 0x5E → same hit. Load 0x60 → `fwd_hit` = 0.
- **Wrap-around:** 10 stores 0x0..0x9 to 0x50+4i with `mem_ready` toggling 1,0,1,0 → pointers wrap twice and memory sees data 0..9 in order.
- **Simultaneous enqueue and drain:** `count` = 2 and `mem_ready` = 1 while a store arrives → `count` stays 2 and the head advances.
- **Reset mid-operation:** 3 pending stores, assert `reset` between edges → `mem_we` = 0 and `count` = 0 immediately. After release, a store 0x0→0x64 is the next and only memory write.
